// File: rtl/auto_counter_pkg.sv
// Shared constants for the auto counter: mode encodings and the seven-segment
// glyph table (active-low, segment a = bit0 .. g = bit6).
package auto_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] segDecode(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = SEG_A;
      4'hB: glyph = SEG_B;
      4'hC: glyph = SEG_C;
      4'hD: glyph = SEG_D;
      4'hE: glyph = SEG_E;
      4'hF: glyph = SEG_F;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/auto_counter_4bit_if.sv
// Control and status bundle between the board logic and the auto counter.
// Optional macro SEVENSEG_EN adds the seven-segment output.
interface auto_counter_4bit_if #(
  parameter int WIDTH = 4
);

  logic             clk_slow;
  logic             enable;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
`ifdef SEVENSEG_EN
  logic [6:0]       seg;
`endif

  modport master (
    output clk_slow, enable, mode, load, load_val,
`ifdef SEVENSEG_EN
    input  seg,
`endif
    input  count, dir, tc
  );

  modport slave (
    input  clk_slow, enable, mode, load, load_val,
`ifdef SEVENSEG_EN
    output seg,
`endif
    output count, dir, tc
  );

endinterface

// File: rtl/auto_counter_4bit_tick_sync.sv
// Synchronizes the slow divided clock into the clk domain and emits a
// one-cycle tick per rising edge, suppressed until a genuine low is seen.
module tick_sync
  import auto_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // valid_q marks when the chain output is a real sample rather than the reset
  // zero, so a high input across reset release cannot arm on a fake low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      valid_q <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= synced;
      if (valid_q[SYNC_STAGES-1] && !synced) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign tick = synced & ~prev_q & armed_q;

endmodule

// File: rtl/auto_counter_4bit.sv
// Tick-driven up/down/bounce/hold counter with load and terminal-count pulse.
// Optional macro SEVENSEG_EN adds a registered seven-segment decode of count.
module auto_counter_4bit
  import auto_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_VAL     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  auto_counter_4bit_if.slave        bus
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  tick_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.clk_slow),
    .tick     (tick)
  );

  // Load beats a tick; every wrap or turn-around raises tc for one cycle.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    end else if (tick && bus.enable) begin
      case (bus.mode)
        MODE_UP: begin
          dir_d = 1'b1;
          if (count_q == MAX_W) begin
            count_d = ZERO_W;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + ONE_W;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (count_q == ZERO_W) begin
            count_d = MAX_W;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - ONE_W;
          end
        end
        MODE_BOUNCE: begin
          if (dir_q && count_q == MAX_W) begin
            count_d = MAX_W - ONE_W;
            dir_d   = 1'b0;
            tc_d    = 1'b1;
          end else if (!dir_q && count_q == ZERO_W) begin
            count_d = ONE_W;
            dir_d   = 1'b1;
            tc_d    = 1'b1;
          end else if (dir_q) begin
            count_d = count_q + ONE_W;
          end else begin
            count_d = count_q - ONE_W;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.tc    = tc_q;

`ifdef SEVENSEG_EN
  logic [6:0] seg_q, seg_d;

  // Values beyond one hex digit only arise with WIDTH > 4 and show blank.
  always_comb begin
    seg_d = SEG_BLANK;
    if (32'(count_q) <= 32'd15) begin
      seg_d = segDecode(4'(count_q));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_0;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign bus.seg = seg_q;
`endif

endmodule

// File: doc/auto_counter_4bit.md
Name: auto_counter_4bit

Overview:
Downstream consumer of the 1 Hz divider. Samples the divided clock `clk_slow` as data in the `clk` domain and turns each rising edge into a one-cycle tick. Advances a 4-bit counter on each tick in up, down, bounce or hold mode. Provides a synchronous load and a terminal-count pulse; drives board LEDs and an optional seven-segment display.

Parameters:
WIDTH, 4, counter width in bits.
MAX_VAL, 15, terminal value; legal range 1 .. 2**WIDTH-1.
SYNC_STAGES, 2, synchronizer depth on `clk_slow`; minimum 2.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
clk_slow  in  1  divided clock from the divider; treated as asynchronous data, never used as a clock.
enable  in  1  high = ticks advance the counter; low = ticks discarded.
mode  in  2  00 up, 01 down, 10 bounce, 11 hold.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value to load.
count  out  WIDTH  current count (registered).
dir  out  1  current direction: 1 = up, 0 = down (registered).
tc  out  1  one-clk pulse on wrap or bounce turn-around (registered).

Behaviour:
- Interface: reset is `reset`, asynchronous, active-high; clock is `clk`.
- Reset values: count=0, dir=1, tc=0, synchronizer chain=0, edge-prev flop=0, arm flag=0.
- Tick generation:
  - `clk_slow` passes through SYNC_STAGES flops.
  - tick = synced & ~prev & armed.
  - armed sets on the first clk where synced==0 after reset. No spurious tick occurs if `clk_slow` is high while reset releases.
- Latency: `clk_slow` high first sampled at edge N gives tick during cycle N+SYNC_STAGES-1; count updates at edge N+SYNC_STAGES.
- Priority per clk edge: load > (tick & enable) > hold.
- Load:
  - count <= min(load_val, MAX_VAL). Takes effect on the next edge regardless of enable or mode.
  - tc=0 and dir is unchanged.
  - A tick in the same cycle is dropped.
- enable low: ticks are discarded, not queued. count, dir and tc hold; tc=0.
- Mode up (on tick): dir<=1.
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: count<=0, tc=1.
- Mode down (on tick): dir<=0.
  - count>0: count-1.
  - count==0: count<=MAX_VAL, tc=1.
- Mode bounce (on tick):
  - dir==1 and count==MAX_VAL: count<=MAX_VAL-1, dir<=0, tc=1.
  - dir==0 and count==0: count<=1, dir<=1, tc=1.
  - Otherwise: step in direction dir.
- Mode hold: ticks ignored; count and dir unchanged.
- Mode change: sampled only on ticks; the new mode applies from the next tick. count is never re-clamped.
- count>MAX_VAL is unreachable by design.
- tc: high exactly one clk, in the cycle following the updating edge; otherwise 0.
- Arithmetic: WIDTH-bit unsigned, with explicit compares to 0 and MAX_VAL. No reliance on natural overflow; MAX_VAL may be less than 2**WIDTH-1.

Optional Feature:
SEVENSEG_EN
- Defined: adds output `seg` (7 bits, active-low, segments a..g = bit0..bit6). It is the registered hex decode of count, lagging count by one clk, and resets to 7'b1000000 (digit 0).
- Undefined: `seg` port and decoder are absent; all other behaviour is identical.

Decomposition:
- Package auto_counter_pkg:
  - MODE_UP/MODE_DOWN/MODE_BOUNCE/MODE_HOLD 2-bit constants.
  - Seven-segment lookup constants for 0-F.
  - SEG_BLANK constant.
- Sub-module tick_sync: synchronizer chain + prev flop + arm flag. Ports clk, reset, async_in, tick. Parameter SYNC_STAGES. Instantiated once.

Test Plan:
- Reset with `clk_slow` held high, release reset -> no tick and count stays 0 until `clk_slow` falls and rises again; then count=1 exactly SYNC_STAGES clks after the rise is first sampled.
- Mode up, enable=1, 16 slow edges from 0 -> count runs 1..15 then 0; a single 1-clk tc occurs at the 15->0 wrap.
- Mode down from 0 with MAX_VAL=9 -> first tick gives count=9 and tc=1; next tick gives 8.
- Mode bounce from 0, 20 ticks with MAX_VAL=5 -> sequence 1,2,3,4,5,4,3,2,1,0,1,... with dir toggling and tc at the 5->4 and 0->1 turns.
- load=1 with load_val=12, MAX_VAL=9, coincident with a tick -> count=9, tick dropped, tc=0. Then enable=0 across 3 ticks -> count stays 9.
- SEVENSEG_EN defined, count steps 3->4 -> seg changes from 7'b0110000 to 7'b0011001 one clk after count.
